// File: rtl/dac_spi_tx.sv
// LTC2624 SPI writer: latches a 32-bit command frame on start and shifts it out MSB-first.
// Latency: DAC_CS falls 1 cycle after start; busy for 66*CLK_DIV cycles; start ignored while busy.
module dac_spi_tx #(
   parameter int CLK_DIV = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  dac_cmd,
   input  logic [3:0]  dac_addr,
   input  logic [11:0] dac_data,
   output logic        busy,
   output logic        done,
   output logic        SPI_MOSI,
   output logic        SPI_CLK,
   output logic        DAC_CS,
   output logic        DAC_CLR,
   output logic        AMP_CS,
   output logic        SPI_SS_B,
   output logic        SF_CE0,
   output logic        FPGA_INIT_B,
   output logic        ADC_CONV
);

   // One-bit prescaler when CLK_DIV is 1, so the counter never collapses to zero width.
   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_LO,
      SHIFT_HI,
      CS_HOLD,
      GAP
   } state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] pre, pre_nxt;
   logic [4:0]    bit_cnt, bit_cnt_nxt;
   logic [31:0]   shreg, shreg_nxt;
   logic          cs_nxt, sck_nxt, mosi_nxt, busy_nxt, done_nxt;
   logic          phase_end;

   assign phase_end = (pre == PRE_LAST);

   always_comb begin
      state_nxt   = state;
      pre_nxt     = pre;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;

      if (state == IDLE) begin
         if (start) begin
            state_nxt   = SHIFT_LO;
            pre_nxt     = '0;
            bit_cnt_nxt = 5'd31;
            shreg_nxt   = {8'h00, dac_cmd, dac_addr, dac_data, 4'h0};
         end
      end else begin
         pre_nxt = phase_end ? '0 : pre + 1'b1;
         if (phase_end) begin
            case (state)
               SHIFT_LO: state_nxt = SHIFT_HI;
               SHIFT_HI: begin
                  if (bit_cnt != 5'd0) begin
                     bit_cnt_nxt = bit_cnt - 5'd1;
                     shreg_nxt   = {shreg[30:0], 1'b0};
                     state_nxt   = SHIFT_LO;
                  end else begin
                     state_nxt = CS_HOLD;
                  end
               end
               CS_HOLD: state_nxt = GAP;
               GAP:     state_nxt = IDLE;
               default: state_nxt = IDLE;
            endcase
         end
      end

      // Outputs are decoded from the next state so every pin comes straight off a flop.
      cs_nxt   = !(state_nxt inside {SHIFT_LO, SHIFT_HI, CS_HOLD});
      sck_nxt  = (state_nxt == SHIFT_HI);
      mosi_nxt = (state_nxt inside {SHIFT_LO, SHIFT_HI}) && shreg_nxt[31];
      busy_nxt = (state_nxt != IDLE);
      done_nxt = (state == CS_HOLD) && (state_nxt == GAP);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         pre      <= '0;
         bit_cnt  <= 5'd0;
         shreg    <= 32'h0;
         DAC_CS   <= 1'b1;
         SPI_CLK  <= 1'b0;
         SPI_MOSI <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         DAC_CLR  <= 1'b0;
      end else begin
         state    <= state_nxt;
         pre      <= pre_nxt;
         bit_cnt  <= bit_cnt_nxt;
         shreg    <= shreg_nxt;
         DAC_CS   <= cs_nxt;
         SPI_CLK  <= sck_nxt;
         SPI_MOSI <= mosi_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         DAC_CLR  <= 1'b1;
      end
   end

   // Other devices sharing the SPI bus stay deselected.
   assign AMP_CS      = 1'b1;
   assign SPI_SS_B    = 1'b1;
   assign SF_CE0      = 1'b1;
   assign FPGA_INIT_B = 1'b1;
   assign ADC_CONV    = 1'b0;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: a CLK_DIV=2 and a CLK_DIV=1 instance checked every cycle against a
// frame-position model, plus directed frame/length checks with hand-computed values.
module tb_dac_spi_tx;

   logic        clk;
   logic        reset;
   logic [1:0]  start;
   logic [3:0]  dac_cmd;
   logic [3:0]  dac_addr;
   logic [11:0] dac_data;
   logic [1:0]  busy, done, mosi, sck, cs, clr, amp, ss, sf, init, adc;

   int tests = 0;
   int fails = 0;

   dac_spi_tx #(.CLK_DIV(2)) u_d2 (
      .clk(clk), .reset(reset), .start(start[0]),
      .dac_cmd(dac_cmd), .dac_addr(dac_addr), .dac_data(dac_data),
      .busy(busy[0]), .done(done[0]), .SPI_MOSI(mosi[0]), .SPI_CLK(sck[0]),
      .DAC_CS(cs[0]), .DAC_CLR(clr[0]), .AMP_CS(amp[0]), .SPI_SS_B(ss[0]),
      .SF_CE0(sf[0]), .FPGA_INIT_B(init[0]), .ADC_CONV(adc[0])
   );

   dac_spi_tx #(.CLK_DIV(1)) u_d1 (
      .clk(clk), .reset(reset), .start(start[1]),
      .dac_cmd(dac_cmd), .dac_addr(dac_addr), .dac_data(dac_data),
      .busy(busy[1]), .done(done[1]), .SPI_MOSI(mosi[1]), .SPI_CLK(sck[1]),
      .DAC_CS(cs[1]), .DAC_CLR(clr[1]), .AMP_CS(amp[1]), .SPI_SS_B(ss[1]),
      .SF_CE0(sf[1]), .FPGA_INIT_B(init[1]), .ADC_CONV(adc[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dv(input int g);
      return (g == 0) ? 2 : 1;
   endfunction

   // Expected {cs, sck, mosi, busy, done} in cycle kk of a frame (kk=0 means idle).
   function automatic logic [4:0] model_out(input int kk, input int d, input logic [31:0] ff);
      logic [4:0] r;
      int half;
      if (kk == 0) return 5'b10000;
      half = (kk - 1) / d;
      r[4] = (kk > 65 * d);
      r[3] = (kk <= 64 * d) && (half % 2 == 1);
      r[2] = (kk <= 64 * d) ? ff[31 - half / 2] : 1'b0;
      r[1] = 1'b1;
      r[0] = (kk == 65 * d + 1);
      return r;
   endfunction

   // Model: cycle position within the current frame and the frame word it latched.
   int          k [2];
   logic [31:0] f [2];
   logic [1:0]  clr_exp;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int g = 0; g < 2; g++) k[g] <= 0;
         clr_exp <= 2'b00;
      end else begin
         clr_exp <= 2'b11;
         for (int g = 0; g < 2; g++) begin
            if (k[g] == 0) begin
               if (start[g]) begin
                  k[g] <= 1;
                  f[g] <= {8'h00, dac_cmd, dac_addr, dac_data, 4'h0};
               end
            end else if (k[g] == 66 * dv(g)) begin
               k[g] <= 0;
            end else begin
               k[g] <= k[g] + 1;
            end
         end
      end
   end

   // Measurement state, owned by the sampling process below.
   int          cs_run[2], cs_len[2], cs_hi_run[2], cs_hi_min[2];
   int          busy_run[2], busy_len[2], done_cnt[2], done_at[2];
   int          frame_cnt[2], edges[2], last_edges[2];
   int          since_rise[2], per_min[2], per_max[2], hi_run[2], hi_max[2];
   int          seen_epoch[2];
   logic [31:0] sh[2], last_frame[2];
   logic [1:0]  sck_prev = 2'b00;
   int          epoch = 0;

   initial begin
      for (int g = 0; g < 2; g++) begin
         cs_run[g] = 0; cs_len[g] = 0; cs_hi_run[g] = 0; cs_hi_min[g] = 0;
         busy_run[g] = 0; busy_len[g] = 0; done_cnt[g] = 0; done_at[g] = 0;
         frame_cnt[g] = 0; edges[g] = 0; last_edges[g] = 0; since_rise[g] = 0;
         per_min[g] = 0; per_max[g] = 0; hi_run[g] = 0; hi_max[g] = 0;
         seen_epoch[g] = -1; sh[g] = 32'h0; last_frame[g] = 32'h0;
      end
   end

   always @(posedge clk) begin
      #1;
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("outputs_d%0d", dv(g)),
             {27'h0, cs[g], sck[g], mosi[g], busy[g], done[g]},
             {27'h0, model_out(k[g], dv(g), f[g])});
         chk($sformatf("dac_clr_d%0d", dv(g)), {31'h0, clr[g]}, {31'h0, clr_exp[g]});
         chk($sformatf("idle_pins_d%0d", dv(g)), {27'h0, amp[g], ss[g], sf[g], init[g], adc[g]},
             32'h1E);

         if (seen_epoch[g] != epoch) begin
            seen_epoch[g] = epoch;
            cs_hi_min[g] = 1000000; per_min[g] = 1000000; per_max[g] = 0; hi_max[g] = 0;
         end
         if (reset) begin
            cs_run[g] = 0; cs_hi_run[g] = 0; busy_run[g] = 0;
            sh[g] = 32'h0; edges[g] = 0; hi_run[g] = 0;
         end else begin
            since_rise[g]++;
            if (sck[g] && !sck_prev[g]) begin
               if (edges[g] != 0) begin
                  if (since_rise[g] < per_min[g]) per_min[g] = since_rise[g];
                  if (since_rise[g] > per_max[g]) per_max[g] = since_rise[g];
               end
               since_rise[g] = 0;
               sh[g] = {sh[g][30:0], mosi[g]};
               edges[g]++;
            end
            if (sck[g]) begin
               hi_run[g]++;
               if (hi_run[g] > hi_max[g]) hi_max[g] = hi_run[g];
            end else begin
               hi_run[g] = 0;
            end
            if (!cs[g]) begin
               cs_run[g]++;
               if (cs_hi_run[g] != 0 && cs_hi_run[g] < cs_hi_min[g]) cs_hi_min[g] = cs_hi_run[g];
               cs_hi_run[g] = 0;
            end else begin
               cs_hi_run[g]++;
               if (cs_run[g] != 0) begin
                  cs_len[g] = cs_run[g];
                  cs_run[g] = 0;
                  last_frame[g] = sh[g];
                  last_edges[g] = edges[g];
                  frame_cnt[g]++;
                  sh[g] = 32'h0;
                  edges[g] = 0;
               end
            end
            if (busy[g]) begin
               busy_run[g]++;
            end else if (busy_run[g] != 0) begin
               busy_len[g] = busy_run[g];
               busy_run[g] = 0;
            end
            if (done[g]) begin
               done_cnt[g]++;
               done_at[g] = busy_run[g];
            end
         end
         sck_prev[g] = sck[g];
      end
   end

   task automatic send(input int g, input logic [3:0] c, input logic [3:0] a, input logic [11:0] d);
      @(negedge clk);
      dac_cmd = c; dac_addr = a; dac_data = d; start[g] = 1'b1;
      @(negedge clk);
      start[g] = 1'b0;
   endtask

   task automatic wait_idle(input int g, input int budget, input string name);
      int n;
      for (n = 0; n < budget; n++) begin
         @(negedge clk);
         if (!busy[g]) break;
      end
      if (n == budget) chk({name, "_timeout"}, {31'h0, busy[g]}, 32'h0);
   endtask

   int fb, db;

   initial begin
      reset = 1'b1; start = 2'b00; dac_cmd = 4'h0; dac_addr = 4'h0; dac_data = 12'h0;

      // Reset
      repeat (3) @(negedge clk);
      chk("rst_cs", {31'h0, cs[0]}, 32'h1);
      chk("rst_sck_mosi", {30'h0, sck[0], mosi[0]}, 32'h0);
      chk("rst_busy_done", {30'h0, busy[0], done[0]}, 32'h0);
      chk("rst_dac_clr", {30'h0, clr}, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #2;
      chk("dac_clr_release", {30'h0, clr}, 32'h3);

      // Single write, D=2
      fb = frame_cnt[0]; db = done_cnt[0];
      send(0, 4'h3, 4'hF, 12'hABC);
      wait_idle(0, 300, "single");
      @(negedge clk);
      chk("single_frames", frame_cnt[0] - fb, 1);
      chk("single_word", last_frame[0], 32'h003FABC0);
      chk("single_edges", last_edges[0], 32);
      chk("single_cs_len", cs_len[0], 130);
      chk("single_done_at", done_at[0], 131);
      chk("single_done_cnt", done_cnt[0] - db, 1);
      chk("single_busy_len", busy_len[0], 132);

      // Input change and start pulse mid-frame are ignored
      fb = frame_cnt[0];
      send(0, 4'h3, 4'hF, 12'hABC);
      repeat (40) @(negedge clk);
      dac_data = 12'h123; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      wait_idle(0, 300, "hold");
      repeat (150) @(negedge clk);
      chk("hold_frames", frame_cnt[0] - fb, 1);
      chk("hold_word", last_frame[0], 32'h003FABC0);
      chk("hold_busy_len", busy_len[0], 132);

      // Back-to-back with start held
      epoch++;
      fb = frame_cnt[0]; db = done_cnt[0];
      @(negedge clk);
      dac_cmd = 4'h3; dac_addr = 4'h0; dac_data = 12'hFFF; start[0] = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (done_cnt[0] - db >= 3) break;
      end
      start[0] = 1'b0;
      chk("b2b_done_reached", {31'h0, (done_cnt[0] - db) >= 3}, 32'h1);
      wait_idle(0, 300, "b2b");
      @(negedge clk);
      chk("b2b_frames", frame_cnt[0] - fb, 3);
      chk("b2b_dones", done_cnt[0] - db, 3);
      chk("b2b_word", last_frame[0], 32'h0030FFF0);
      chk("b2b_cs_gap_ge3", {31'h0, cs_hi_min[0] >= 3}, 32'h1);

      // Reset after the 10th SCK rising edge aborts the frame
      db = done_cnt[0];
      send(0, 4'h3, 4'hF, 12'hABC);
      for (int n = 0; n < 200; n++) begin
         if (edges[0] >= 10) break;
         @(negedge clk);
      end
      chk("abort_edges_reached", edges[0], 10);
      reset = 1'b1;
      #1;
      chk("abort_cs", {31'h0, cs[0]}, 32'h1);
      chk("abort_sck", {31'h0, sck[0]}, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_no_done", done_cnt[0] - db, 0);
      fb = frame_cnt[0];
      send(0, 4'h3, 4'h1, 12'h800);
      wait_idle(0, 300, "after_abort");
      @(negedge clk);
      chk("after_abort_frames", frame_cnt[0] - fb, 1);
      chk("after_abort_word", last_frame[0], 32'h00318000);
      chk("after_abort_edges", last_edges[0], 32);

      // CLK_DIV=1
      epoch++;
      @(negedge clk);
      fb = frame_cnt[1];
      send(1, 4'h3, 4'hF, 12'hABC);
      wait_idle(1, 200, "d1");
      @(negedge clk);
      chk("d1_frames", frame_cnt[1] - fb, 1);
      chk("d1_word", last_frame[1], 32'h003FABC0);
      chk("d1_edges", last_edges[1], 32);
      chk("d1_cs_len", cs_len[1], 65);
      chk("d1_busy_len", busy_len[1], 66);
      chk("d1_done_at", done_at[1], 66);
      chk("d1_period_min", per_min[1], 2);
      chk("d1_period_max", per_max[1], 2);
      chk("d1_sck_high", hi_max[1], 1);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
